// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock handshake and reset/status signals around the PLL reset sequencer
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       sw_relock;
    logic       fault_clear;
    logic       pll_rst;
    logic       rst_out0_n;
    logic       rst_out1_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [2:0] state;
    modport master (
        output pll_locked, sw_relock, fault_clear,
        input  pll_rst, rst_out0_n, rst_out1_n, ready, fault, retry_cnt, state
    );
    modport slave (
        input  pll_locked, sw_relock, fault_clear,
        output pll_rst, rst_out0_n, rst_out1_n, ready, fault, retry_cnt, state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: resets the PLL, waits for stable lock, then releases staggered domain resets
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 3
) (
    input logic                 refclk,
    input logic                 rst_n,
    pll_reset_sequencer_if.slave io
);
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(STAGGER_CYCLES + 1);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t        state, nxt, to_state;
    logic          sync1, locked_s;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] stag_cnt;
    logic [3:0]    retry, retry_nxt, retry_inc;
    logic          pll_rst_q, out0_q, out1_q, ready_q, fault_q;
    logic          hold_done, stable_done, stagger_done, timed_out, lost, tmo_run;

    assign hold_done    = int'(hold_cnt) + 1 >= RST_HOLD_CYCLES;
    assign stable_done  = int'(stab_cnt) + 1 >= LOCK_STABLE_CYCLES;
    assign stagger_done = int'(stag_cnt) + 1 >= STAGGER_CYCLES;
    assign timed_out    = int'(tmo_cnt) + 1 >= LOCK_TIMEOUT_CYCLES;
    assign lost         = !locked_s || io.sw_relock;
    assign retry_inc    = (retry == 4'hf) ? retry : retry + 4'd1;
    assign to_state     = (int'(retry_inc) == MAX_RETRIES) ? FAULT : RESET_PLL;
    assign tmo_run      = (state == WAIT_LOCK || state == STABILIZE) && (nxt == WAIT_LOCK || nxt == STABILIZE);

    // next-state decision; a real lock loss outranks sw_relock, which outranks the lock timeout
    always_comb begin
        nxt       = state;
        retry_nxt = retry;
        case (state)
            RESET_PLL: nxt = hold_done ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: begin
                if (io.sw_relock) nxt = RESET_PLL;
                else if (timed_out) begin
                    nxt       = to_state;
                    retry_nxt = retry_inc;
                end else if (locked_s) nxt = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_s) nxt = WAIT_LOCK;
                else if (io.sw_relock) nxt = RESET_PLL;
                else if (timed_out) begin
                    nxt       = to_state;
                    retry_nxt = retry_inc;
                end else if (stable_done) nxt = RELEASE;
            end
            RELEASE: begin
                if (lost) nxt = RESET_PLL;
                else if (stagger_done) begin
                    nxt       = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: nxt = lost ? RESET_PLL : RUN;
            FAULT: begin
                if (io.fault_clear) begin
                    nxt       = RESET_PLL;
                    retry_nxt = '0;
                end
            end
            default: nxt = RESET_PLL;
        endcase
    end

    // two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= io.pll_locked;
            locked_s <= sync1;
        end
    end

    // state, phase counters and outputs decoded from the next state so they change with it
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            retry     <= '0;
            hold_cnt  <= '0;
            stab_cnt  <= '0;
            tmo_cnt   <= '0;
            stag_cnt  <= '0;
            pll_rst_q <= 1'b1;
            out0_q    <= 1'b0;
            out1_q    <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= nxt;
            retry     <= retry_nxt;
            hold_cnt  <= (state == RESET_PLL && nxt == RESET_PLL) ? hold_cnt + 1'b1 : '0;
            stab_cnt  <= (state == STABILIZE && nxt == STABILIZE) ? stab_cnt + 1'b1 : '0;
            stag_cnt  <= (state == RELEASE && nxt == RELEASE) ? stag_cnt + 1'b1 : '0;
            tmo_cnt   <= tmo_run ? tmo_cnt + 1'b1 : '0;
            pll_rst_q <= nxt == RESET_PLL || nxt == FAULT;
            out0_q    <= nxt == RELEASE || nxt == RUN;
            out1_q    <= nxt == RUN;
            ready_q   <= nxt == RUN;
            fault_q   <= nxt == FAULT;
        end
    end

    assign io.pll_rst    = pll_rst_q;
    assign io.rst_out0_n = out0_q;
    assign io.rst_out1_n = out1_q;
    assign io.ready      = ready_q;
    assign io.fault      = fault_q;
    assign io.retry_cnt  = retry;
    assign io.state      = state;
endmodule
